// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB write-back slice.
// Write-back source encodings, run-state encoding and fixed ISA widths.
package wb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] WB_ILL = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_e;

endpackage

// File: rtl/writeback_mux.sv
// Combinational write-back source select and register-file write-enable qualification.
// The illegal select falls back to the ALU value but never enables the write.
module writeback_mux
    import wb_pkg::*;
(
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [1:0]        sel_i,
    input  logic              valid_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] write_data_o,
    output logic              reg_write_o
);

    always_comb begin
        write_data_o = alu_i;
        unique case (sel_i)
            WB_ALU:  write_data_o = alu_i;
            WB_MEM:  write_data_o = mem_i;
            WB_PC:   write_data_o = pc_i;
            WB_ILL:  write_data_o = alu_i;
            default: write_data_o = alu_i;
        endcase
    end

    assign reg_write_o = valid_i & reg_write_i & (sel_i != WB_ILL);

endmodule

// File: rtl/memwb_writeback.sv
// MEM/WB pipeline latch with write-back drive to the register file, halt tracking,
// retired-instruction counting and a sticky illegal-write-back flag.
module memwb_writeback
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] memReadData,
    input  logic [DATA_W-1:0] pcPlus2,
    input  logic [REG_W-1:0]  destReg,
    input  logic              RegWrite_in,
    input  logic [1:0]        wbSel,
    input  logic              dump_in,
    output logic [DATA_W-1:0] writeData,
    output logic [REG_W-1:0]  writeRegister,
    output logic              RegWrite,
    output logic              valid_out,
    output logic              halt,
    output logic [DATA_W-1:0] retired,
    output logic              err
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] aluResult_q, aluResult_d;
    logic [DATA_W-1:0] memReadData_q, memReadData_d;
    logic [DATA_W-1:0] pcPlus2_q, pcPlus2_d;
    logic [REG_W-1:0]  destReg_q, destReg_d;
    logic              RegWrite_q, RegWrite_d;
    logic [1:0]        wbSel_q, wbSel_d;
    logic              dump_q, dump_d;
    logic [DATA_W-1:0] retired_q, retired_d;
    logic              err_q, err_d;
    run_state_e        state_q, state_d;
    logic              halting;

    // The HALT retiring this cycle also squashes whatever would be captured behind it,
    // so valid_q stays 0 for the whole HALTED period.
    assign halting = (state_q == ST_HALTED) | (valid_q & dump_q);

    always_comb begin
        valid_d       = 1'b0;
        aluResult_d   = aluResult_q;
        memReadData_d = memReadData_q;
        pcPlus2_d     = pcPlus2_q;
        destReg_d     = destReg_q;
        RegWrite_d    = RegWrite_q;
        wbSel_d       = wbSel_q;
        dump_d        = dump_q;
        if (!halting && !stall_in) begin
            valid_d       = valid_in;
            aluResult_d   = aluResult;
            memReadData_d = memReadData;
            pcPlus2_d     = pcPlus2;
            destReg_d     = destReg;
            RegWrite_d    = RegWrite_in;
            wbSel_d       = wbSel;
            dump_d        = dump_in;
        end
    end

    always_comb begin
        retired_d = retired_q + {{(DATA_W-1){1'b0}}, valid_q};
        err_d     = err_q | (valid_q & RegWrite_q & (wbSel_q == WB_ILL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            aluResult_q   <= '0;
            memReadData_q <= '0;
            pcPlus2_q     <= '0;
            destReg_q     <= '0;
            RegWrite_q    <= 1'b0;
            wbSel_q       <= WB_ALU;
            dump_q        <= 1'b0;
            retired_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            aluResult_q   <= aluResult_d;
            memReadData_q <= memReadData_d;
            pcPlus2_q     <= pcPlus2_d;
            destReg_q     <= destReg_d;
            RegWrite_q    <= RegWrite_d;
            wbSel_q       <= wbSel_d;
            dump_q        <= dump_d;
            retired_q     <= retired_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (valid_q && dump_q) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        halt = (state_q == ST_HALTED);
    end

    writeback_mux u_writeback_mux (
        .alu_i        (aluResult_q),
        .mem_i        (memReadData_q),
        .pc_i         (pcPlus2_q),
        .sel_i        (wbSel_q),
        .valid_i      (valid_q),
        .reg_write_i  (RegWrite_q),
        .write_data_o (writeData),
        .reg_write_o  (RegWrite)
    );

    assign writeRegister = destReg_q;
    assign valid_out     = valid_q;
    assign retired       = retired_q;
    assign err           = err_q;

endmodule
